// File: rtl/tick_period_monitor.sv
// Measures the rise-to-rise period of a slow asynchronous tick, tracks lock
// against a nominal period, counts out-of-range periods and flags lost ticks.
module tick_period_monitor #(
    parameter int EXPECTED_CYCLES = 100_000_000,
    parameter int TOLERANCE       = 1_000,
    parameter int LOCK_COUNT      = 3,
    parameter int TIMEOUT_CYCLES  = 150_000_000
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        i_tick,
    output logic [27:0] o_period,
    output logic        o_period_valid,
    output logic        o_locked,
    output logic        o_timeout,
    output logic [7:0]  o_err_count
);

    // state      | meaning
    // WAIT_FIRST | no reference rise held; next rise only starts a measurement
    // MEASURE    | reference rise held; next rise completes a period
    localparam logic [0:0] WAIT_FIRST = 1'b0;
    localparam logic [0:0] MEASURE    = 1'b1;

    localparam logic [27:0] RANGE_LO = 28'(EXPECTED_CYCLES - TOLERANCE);
    localparam logic [27:0] RANGE_HI = 28'(EXPECTED_CYCLES + TOLERANCE);
    localparam logic [27:0] TIMEOUT  = 28'(TIMEOUT_CYCLES);
    localparam logic [27:0] CNT_MAX  = '1;
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_COUNT);

    logic [0:0]  state;
    logic        sync_a;
    logic        sync_b;
    logic        sync_c;
    logic        rise_q;
    logic [27:0] cnt;
    logic [3:0]  streak;
    logic [3:0]  streak_next;
    logic        in_range;

    assign in_range    = (cnt >= RANGE_LO) && (cnt <= RANGE_HI);
    assign streak_next = (streak == LOCK_N) ? streak : streak + 4'd1;

    // cnt holds the cycles elapsed since the last processed rise, so the value
    // read on the next processed rise is exactly the period.  rise_q adds one
    // register stage so that valid lands three edges after the raw sample.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state          <= WAIT_FIRST;
            sync_a         <= 1'b0;
            sync_b         <= 1'b0;
            sync_c         <= 1'b0;
            rise_q         <= 1'b0;
            cnt            <= '0;
            streak         <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_locked       <= 1'b0;
            o_timeout      <= 1'b0;
            o_err_count    <= '0;
        end else begin
            sync_a         <= i_tick;
            sync_b         <= sync_a;
            sync_c         <= sync_b;
            rise_q         <= sync_b & ~sync_c;
            o_period_valid <= 1'b0;

            if (rise_q) begin
                cnt       <= 28'd1;
                o_timeout <= 1'b0;
                state     <= MEASURE;
                if (state == MEASURE) begin
                    o_period       <= cnt;
                    o_period_valid <= 1'b1;
                    if (in_range) begin
                        streak   <= streak_next;
                        o_locked <= (streak_next == LOCK_N);
                    end else begin
                        streak   <= '0;
                        o_locked <= 1'b0;
                        if (o_err_count != 8'hFF)
                            o_err_count <= o_err_count + 8'd1;
                    end
                end
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 28'd1;
                // Fires as the count steps to TIMEOUT+1; a coincident rise wins above.
                if (cnt == TIMEOUT) begin
                    o_timeout <= 1'b1;
                    o_locked  <= 1'b0;
                    streak    <= '0;
                    state     <= WAIT_FIRST;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor with EXPECTED=100, TOL=2, LOCK=3, TIMEOUT=150.
module tb_tick_period_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [27:0] o_period;
    logic        o_period_valid;
    logic        o_locked;
    logic        o_timeout;
    logic [7:0]  o_err_count;

    tick_period_monitor #(
        .EXPECTED_CYCLES(100),
        .TOLERANCE(2),
        .LOCK_COUNT(3),
        .TIMEOUT_CYCLES(150)
    ) dut (
        .i_clk(clk),
        .reset(reset),
        .i_tick(tick),
        .o_period(o_period),
        .o_period_valid(o_period_valid),
        .o_locked(o_locked),
        .o_timeout(o_timeout),
        .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise = 0;
    int n_valid = 0;
    int v_cyc = -1;
    int v_period = -1;
    int v_locked = -1;
    int v_err = -1;
    int to_cyc = -1;
    logic to_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (o_period_valid === 1'b1) begin
            n_valid++;
            v_cyc    = cyc;
            v_period = int'(o_period);
            v_locked = int'(o_locked);
            v_err    = int'(o_err_count);
        end
        if (o_timeout === 1'b1 && to_prev !== 1'b1) to_cyc = cyc;
        to_prev = o_timeout;
    end

    // Entered and left on a falling edge; the rise is sampled on the next rising edge.
    task automatic run(input int p);
        tick = 1'b1;
        last_rise = cyc + 1;
        repeat (p / 2) @(negedge clk);
        tick = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic test_reset();
        int n0;
        logic [39:0] outs;
        reset = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        n0 = n_valid;
        for (int i = 0; i < 20; i++) begin
            tick = ((i % 4) < 2);
            @(negedge clk);
            outs = {o_period, o_period_valid, o_locked, o_timeout, o_err_count, 1'b0};
            tests++;
            if (outs !== 40'd0) begin
                $display("FAIL reset_outs[%0d]: got %h expected 0", i, outs);
                fails++;
            end
        end
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (n_valid !== n0) begin
            $display("FAIL reset_no_valid: got %0d pulses expected 0", n_valid - n0);
            fails++;
        end
    endtask

    task automatic test_lock();
        int n0;
        n0 = n_valid;
        run(100);
        tests++;
        if (n_valid !== n0) begin
            $display("FAIL first_rise_no_valid: got %0d pulses expected 0", n_valid - n0);
            fails++;
        end
        run(100);
        tests++;
        if (n_valid !== n0 + 1) begin
            $display("FAIL second_rise_valid: got %0d pulses expected 1", n_valid - n0);
            fails++;
        end
        tests++;
        if (v_cyc - last_rise !== 3) begin
            $display("FAIL valid_latency: got %0d expected 3", v_cyc - last_rise);
            fails++;
        end
        tests++;
        if (v_period !== 100 || v_locked !== 0) begin
            $display("FAIL period_100: got period %0d locked %0d expected 100/0", v_period, v_locked);
            fails++;
        end
        run(100);
        tests++;
        if (v_locked !== 0) begin
            $display("FAIL not_locked_at_3rd: got %0d expected 0", v_locked);
            fails++;
        end
        run(100);
        tests++;
        if (n_valid !== n0 + 3 || v_period !== 100 || v_locked !== 1 || v_cyc - last_rise !== 3) begin
            $display("FAIL locked_at_4th: got n %0d period %0d locked %0d lat %0d expected 3/100/1/3",
                     n_valid - n0, v_period, v_locked, v_cyc - last_rise);
            fails++;
        end
    endtask

    task automatic test_out_of_range();
        run(103);
        run(98);
        tests++;
        if (v_period !== 103 || v_locked !== 0 || v_err !== 1 || o_locked !== 1'b0) begin
            $display("FAIL period_103: got period %0d locked %0d err %0d expected 103/0/1",
                     v_period, v_locked, v_err);
            fails++;
        end
        run(98);
        tests++;
        if (v_period !== 98 || v_locked !== 0) begin
            $display("FAIL streak1_98: got period %0d locked %0d expected 98/0", v_period, v_locked);
            fails++;
        end
        run(98);
        tick = 1'b1;
        last_rise = cyc + 1;
        repeat (10) @(negedge clk);
        tests++;
        if (v_period !== 98 || v_locked !== 1 || v_err !== 1) begin
            $display("FAIL relock_98: got period %0d locked %0d err %0d expected 98/1/1",
                     v_period, v_locked, v_err);
            fails++;
        end
    endtask

    task automatic test_timeout();
        int r;
        int n0;
        r  = last_rise;
        n0 = n_valid;
        repeat (190) @(negedge clk);
        tests++;
        if (to_cyc !== r + 153) begin
            $display("FAIL timeout_time: got %0d expected %0d", to_cyc - r, 153);
            fails++;
        end
        tests++;
        if (o_timeout !== 1'b1 || o_locked !== 1'b0 || n_valid !== n0) begin
            $display("FAIL timeout_state: got timeout %0b locked %0b valids %0d expected 1/0/0",
                     o_timeout, o_locked, n_valid - n0);
            fails++;
        end
        tick = 1'b0;
        repeat (5) @(negedge clk);
        run(100);
        tests++;
        if (o_timeout !== 1'b0 || n_valid !== n0) begin
            $display("FAIL timeout_clear: got timeout %0b valids %0d expected 0/0", o_timeout, n_valid - n0);
            fails++;
        end
        run(150);
        tests++;
        if (n_valid !== n0 + 1 || v_period !== 100 || v_cyc - last_rise !== 3) begin
            $display("FAIL after_timeout_valid: got n %0d period %0d lat %0d expected 1/100/3",
                     n_valid - n0, v_period, v_cyc - last_rise);
            fails++;
        end
    endtask

    task automatic test_timeout_boundary();
        int rc;
        int n0;
        int e0;
        run(151);
        rc = last_rise;
        n0 = n_valid;
        e0 = v_err;
        tests++;
        if (v_period !== 150 || o_timeout !== 1'b0 || e0 !== 2) begin
            $display("FAIL period_150: got period %0d timeout %0b err %0d expected 150/0/2",
                     v_period, o_timeout, e0);
            fails++;
        end
        run(100);
        tests++;
        if (to_cyc !== rc + 153) begin
            $display("FAIL period_151_timeout: got %0d expected %0d", to_cyc - rc, 153);
            fails++;
        end
        tests++;
        if (n_valid !== n0 || o_timeout !== 1'b0 || o_err_count !== 8'd2) begin
            $display("FAIL period_151_no_valid: got valids %0d timeout %0b err %0d expected 0/0/2",
                     n_valid - n0, o_timeout, o_err_count);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [39:0] outs;
        run(100);
        run(100);
        tick = 1'b1;
        last_rise = cyc + 1;
        repeat (40) @(negedge clk);
        tick = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (o_locked !== 1'b1) begin
            $display("FAIL locked_before_reset: got %0b expected 1", o_locked);
            fails++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        outs = {o_period, o_period_valid, o_locked, o_timeout, o_err_count, 1'b0};
        tests++;
        if (outs !== 40'd0) begin
            $display("FAIL mid_reset_outs: got %h expected 0", outs);
            fails++;
        end
        n0 = n_valid;
        repeat (50) @(negedge clk);
        run(100);
        tests++;
        if (n_valid !== n0) begin
            $display("FAIL mid_reset_first_rise: got %0d pulses expected 0", n_valid - n0);
            fails++;
        end
        run(100);
        tests++;
        if (n_valid !== n0 + 1 || v_period !== 100 || v_locked !== 0) begin
            $display("FAIL mid_reset_remeasure: got n %0d period %0d locked %0d expected 1/100/0",
                     n_valid - n0, v_period, v_locked);
            fails++;
        end
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock();
        test_out_of_range();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
